// File: rtl/event_fifo_pkg.sv
// Shared constants and operation decoding for the event FIFO.
// Defaults and overflow policy codes live here so that instantiating code can refer to them by name.
package event_fifo_pkg;

  localparam int OVF_DROP       = 0;
  localparam int OVF_OVERWRITE  = 1;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH_LOG2 = 3;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_WRITE,
    OP_READ,
    OP_READ_EMPTY,
    OP_BYPASS,
    OP_READ_WRITE,
    OP_WRITE_FULL
  } fifoOp_t;

  // Clear wins over everything. When both strobes arrive on an empty FIFO, the new event is passed straight through.
  function automatic fifoOp_t decodeOp(logic clr, logic wrStb, logic rdStb,
                                       logic isEmpty, logic isFull);
    fifoOp_t op;
    op = OP_IDLE;
    if (clr)                op = OP_CLEAR;
    else if (wrStb && rdStb) op = isEmpty ? OP_BYPASS : OP_READ_WRITE;
    else if (rdStb)          op = isEmpty ? OP_READ_EMPTY : OP_READ;
    else if (wrStb)          op = isFull ? OP_WRITE_FULL : OP_WRITE;
    return op;
  endfunction

endpackage

// File: rtl/event_fifo_edge_strobe.sv
// Converts a request level into a one-cycle strobe on its rising edge.
// A level that is already high when reset releases does not produce a strobe.
module edge_strobe (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic strobe
);

  logic prevLevel;
  logic primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevLevel <= 1'b0;
      primed    <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values and no ordering dependence exists.
      strobe    <= level & ~prevLevel & primed;
      prevLevel <= level;
      primed    <= 1'b1;
    end
  end

endmodule

// File: rtl/event_fifo.sv
// Edge-triggered event FIFO with a registered read port and a selectable full-write policy.
// The storage is a plain register array. The head, tail and count registers track the occupancy.
module event_fifo
  import event_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int OVF_MODE   = OVF_DROP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic                  wrStb;
  logic                  rdStb;
  logic                  memWe;
  fifoOp_t               op;

  edge_strobe uWrStrobe (.clk(clk), .rst(rst), .level(wr), .strobe(wrStb));
  edge_strobe uRdStrobe (.clk(clk), .rst(rst), .level(rd), .strobe(rdStb));

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  always_comb begin
    op = decodeOp(clr, wrStb, rdStb, empty, full);
  end

  always_comb begin
    // NOTE: default assigned first so every path drives memWe and no latch is inferred.
    memWe = 1'b0;
    case (op)
      OP_WRITE, OP_READ_WRITE: memWe = 1'b1;
      OP_WRITE_FULL:           memWe = (OVF_MODE == OVF_OVERWRITE);
      default:                 memWe = 1'b0;
    endcase
  end

  // NOTE: the storage array has no reset. Its contents are only visible through head/count, and those registers are reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[tail] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (op)
        OP_CLEAR: begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
          dout  <= '0;
          ovf   <= 1'b0;
        end
        OP_WRITE: begin
          tail  <= tail + 1'b1;
          count <= count + 1'b1;
        end
        OP_READ: begin
          dout  <= mem[head];
          head  <= head + 1'b1;
          count <= count - 1'b1;
        end
        OP_READ_EMPTY: dout <= '0;
        OP_BYPASS:     dout <= din;
        OP_READ_WRITE: begin
          // When the FIFO is full, head equals tail. The read still sees the old entry because the array updates at the same edge.
          dout <= mem[head];
          head <= head + 1'b1;
          tail <= tail + 1'b1;
        end
        OP_WRITE_FULL: begin
          ovf <= 1'b1;
          if (OVF_MODE == OVF_OVERWRITE) begin
            head <= head + 1'b1;
            tail <= tail + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_fifo.sv
// Scoreboard bench for event_fifo: drop-newest and overwrite-oldest instances share the same stimulus.
// Each of them is compared against a queue-based reference model.
module tb_event_fifo;
  import event_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic       empty0, empty1, full0, full1, ovf0, ovf1;
  logic [3:0] count0, count1;

  event_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .OVF_MODE(OVF_DROP)) dutDrop (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .din(din),
    .dout(dout0), .empty(empty0), .full(full0), .count(count0), .ovf(ovf0)
  );

  event_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .OVF_MODE(OVF_OVERWRITE)) dutOvr (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .din(din),
    .dout(dout1), .empty(empty1), .full(full1), .count(count1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic       ovf0;
    logic       ovf1;
  } expect_t;

  expect_t sb[$];

  // Reference model: index 0 uses drop-newest, index 1 uses overwrite-oldest.
  logic [7:0] mq [2][$];
  logic [7:0] mDout [2];
  logic       mOvf [2];
  logic       prevWr, prevRd, pendWr, pendRd, armed;

  function automatic expect_t snap();
    expect_t e;
    e.dout0 = mDout[0];
    e.dout1 = mDout[1];
    e.cnt0  = 4'(mq[0].size());
    e.cnt1  = 4'(mq[1].size());
    e.ovf0  = mOvf[0];
    e.ovf1  = mOvf[1];
    return e;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mDout[m] = 8'h00;
      mOvf[m]  = 1'b0;
    end
    prevWr = 1'b0; prevRd = 1'b0; pendWr = 1'b0; pendRd = 1'b0; armed = 1'b0;
  endtask

  task automatic modelFifo(input int m, input logic w, input logic r,
                           input logic c, input logic [7:0] d);
    if (c) begin
      mq[m].delete();
      mDout[m] = 8'h00;
      mOvf[m]  = 1'b0;
    end else if (w && r) begin
      if (mq[m].size() == 0) mDout[m] = d;
      else begin
        mDout[m] = mq[m].pop_front();
        mq[m].push_back(d);
      end
    end else if (r) begin
      if (mq[m].size() == 0) mDout[m] = 8'h00;
      else mDout[m] = mq[m].pop_front();
    end else if (w) begin
      if (mq[m].size() < DEPTH) mq[m].push_back(d);
      else begin
        mOvf[m] = 1'b1;
        if (m == 1) begin
          void'(mq[m].pop_front());
          mq[m].push_back(d);
        end
      end
    end
  endtask

  // Models the next rising edge. A rise seen at one edge takes effect at the following edge.
  task automatic modelEdge();
    logic useWr, useRd;
    useWr  = pendWr;
    useRd  = pendRd;
    pendWr = wr & ~prevWr & armed;
    pendRd = rd & ~prevRd & armed;
    prevWr = wr;
    prevRd = rd;
    armed  = 1'b1;
    for (int m = 0; m < 2; m++) modelFifo(m, useWr, useRd, clr, din);
    sb.push_back(snap());
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; clr = c; din = d;
    modelEdge();
  endtask

  task automatic pulse(input logic w, input logic r, input logic [7:0] d);
    step(w, r, 1'b0, d);
    step(1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic resetPulse(input int cycles, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    rst = 1'b1; wr = w; rd = r; clr = 1'b0; din = d;
    #1;
    check("async_count_drop", 32'(count0), 32'd0);
    check("async_empty_drop", 32'(empty0), 32'd1);
    check("async_count_ovr", 32'(count1), 32'd0);
    check("async_empty_ovr", 32'(empty1), 32'd1);
    modelReset();
    repeat (cycles) begin
      sb.push_back(snap());
      @(negedge clk);
    end
    rst = 1'b0;
    modelEdge();
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        expect_t e;
        e = sb.pop_front();
        check("dout_drop",  32'(dout0),  32'(e.dout0));
        check("count_drop", 32'(count0), 32'(e.cnt0));
        check("empty_drop", 32'(empty0), 32'(e.cnt0 == 4'd0));
        check("full_drop",  32'(full0),  32'(e.cnt0 == 4'd8));
        check("ovf_drop",   32'(ovf0),   32'(e.ovf0));
        check("dout_ovr",   32'(dout1),  32'(e.dout1));
        check("count_ovr",  32'(count1), 32'(e.cnt1));
        check("empty_ovr",  32'(empty1), 32'(e.cnt1 == 4'd0));
        check("full_ovr",   32'(full1),  32'(e.cnt1 == 4'd8));
        check("ovf_ovr",    32'(ovf1),   32'(e.ovf1));
      end
    end
  end

  initial begin : stimulus
    #1 rst = 1'b1;
    #1;
    check("reset_count", 32'(count0), 32'd0);
    check("reset_empty", 32'(empty0), 32'd1);
    check("reset_full",  32'(full0),  32'd0);
    check("reset_ovf",   32'(ovf1),   32'd0);
    check("reset_dout",  32'(dout1),  32'd0);
    modelReset();
    repeat (2) begin
      sb.push_back(snap());
      @(negedge clk);
    end
    rst = 1'b0;
    modelEdge();
    idle(2);

    // Basic in-order write/read
    pulse(1'b1, 1'b0, 8'h11);
    pulse(1'b1, 1'b0, 8'h22);
    pulse(1'b1, 1'b0, 8'h33);
    idle(1);
    check("basic_count3", 32'(count0), 32'd3);
    pulse(1'b0, 1'b1, 8'h00); idle(1);
    check("basic_rd1", 32'(dout0), 32'h11);
    pulse(1'b0, 1'b1, 8'h00); idle(1);
    check("basic_rd2", 32'(dout0), 32'h22);
    pulse(1'b0, 1'b1, 8'h00); idle(1);
    check("basic_rd3", 32'(dout0), 32'h33);
    check("basic_count0", 32'(count0), 32'd0);
    check("basic_empty", 32'(empty0), 32'd1);

    // Bypass on empty, then read of empty
    pulse(1'b1, 1'b1, 8'hA5); idle(1);
    check("bypass_dout", 32'(dout1), 32'hA5);
    check("bypass_count", 32'(count1), 32'd0);
    pulse(1'b0, 1'b1, 8'h00); idle(1);
    check("rd_empty_dout", 32'(dout1), 32'h00);

    // A held write level produces a single write
    repeat (20) step(1'b1, 1'b0, 1'b0, 8'h77);
    idle(2);
    check("held_wr_count", 32'(count0), 32'd1);
    pulse(1'b0, 1'b1, 8'h00); idle(1);

    // Overflow in both policies
    for (int i = 1; i <= 9; i++) pulse(1'b1, 1'b0, 8'(i));
    idle(1);
    check("ovf_full_drop",  32'(full0),  32'd1);
    check("ovf_count_drop", 32'(count0), 32'd8);
    check("ovf_flag_drop",  32'(ovf0),   32'd1);
    check("ovf_flag_ovr",   32'(ovf1),   32'd1);
    for (int i = 1; i <= 8; i++) begin
      pulse(1'b0, 1'b1, 8'h00); idle(1);
      check("ovf_rd_drop", 32'(dout0), 32'(i));
      check("ovf_rd_ovr",  32'(dout1), 32'(i + 1));
    end

    // Simultaneous strobes on a full FIFO, then clear
    step(1'b0, 1'b0, 1'b1, 8'h00); idle(1);
    check("clr_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 8'(8'h10 + i));
    pulse(1'b1, 1'b1, 8'h5A); idle(1);
    check("full_rw_dout",  32'(dout0),  32'h10);
    check("full_rw_count", 32'(count1), 32'd8);
    check("full_rw_ovf",   32'(ovf1),   32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00); idle(1);
    check("clr_count", 32'(count1), 32'd0);
    check("clr_empty", 32'(empty1), 32'd1);
    check("clr_ovf2",  32'(ovf1),   32'd0);
    check("clr_dout",  32'(dout1),  32'h00);

    // Reset mid-run with levels held high across the release
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 8'(8'h41 + i));
    idle(1);
    check("pre_rst_count", 32'(count0), 32'd5);
    resetPulse(2, 1'b1, 1'b1, 8'hC3);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'hC3);
    idle(2);
    check("rst_release_count", 32'(count0), 32'd0);
    check("rst_release_dout",  32'(dout0),  32'h00);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0)
        resetPulse(int'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 8'($urandom));
      else
        step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 3, 8'($urandom));
    end

    idle(3);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
